// File: rtl/mips_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_memory_arbiter
// Purpose  : Shares the single memory datapath port between the instruction
//            fetch requester and the data (load/store) requester. Data wins
//            arbitration unless a waiting fetch has been starved STARVE_MAX
//            times. Each access is one registered command, then a one-cycle
//            acknowledge carrying read data or a misalignment fault.
//            Memory control encoding (4 bits):
//              [3]   WriteEnable
//              [2]   ByteExtend (1 = signed, 0 = unsigned)
//              [1:0] ByteEnable (0 None, 1 Byte, 2 Half, 3 Word)
// Revision : 1.0 - initial release
// ============================================================================
module mips_memory_arbiter #(
  parameter int ADDR_L     = 64,
  parameter int ADDR_W     = $clog2(ADDR_L),
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W+1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [31:0]       i_data,
  input  logic              d_req,
  input  logic [3:0]        d_control,
  input  logic [ADDR_W+1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic [3:0]        m_control,
  output logic [ADDR_W+1:0] m_addr,
  output logic [31:0]       m_data,
  input  logic [31:0]       m_out
);

  localparam int          CW        = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
  localparam logic [1:0]  BE_HALF   = 2'd2;
  localparam logic [1:0]  BE_WORD   = 2'd3;
  localparam logic [3:0]  CTL_NONE  = 4'b0000;
  // Fetches are always unsigned word reads.
  localparam logic [3:0]  CTL_FETCH = 4'b0011;
  localparam logic        OWN_I     = 1'b0;
  localparam logic        OWN_D     = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              owner;
  logic [3:0]        lat_ctl;
  logic [ADDR_W+1:0] m_addr_q;
  logic [31:0]       m_data_q;
  logic [31:0]       i_data_q;
  logic [31:0]       d_rdata_q;
  logic              grant_i, grant_d;
  logic              pick_d, pick_i;
  logic              mis_i, mis_d;

  // Plain arbitration winner; the caller applies the "not the one being acked" rule.
  assign pick_d = d_req && !((cnt == CNT_MAX) && i_req);
  assign pick_i = i_req && !pick_d;

  // Alignment of each requester's pending access.
  assign mis_i = (i_addr[1:0] != 2'b00);
  assign mis_d = ((d_control[1:0] == BE_HALF) && d_addr[0]) ||
                 ((d_control[1:0] == BE_WORD) && (d_addr[1:0] != 2'b00));

  assign m_addr = m_addr_q;
  assign m_data = m_data_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state, grant decisions and handshake outputs.
  always_comb begin
    state_n   = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_ack     = 1'b0;
    i_err     = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    m_control = CTL_NONE;
    i_data    = i_data_q;
    d_rdata   = d_rdata_q;
    case (state)
      S_IDLE: begin
        grant_d = pick_d;
        grant_i = pick_i;
      end
      S_CMD: begin
        m_control = lat_ctl;
        state_n   = S_RESP;
      end
      S_RESP, S_FAULT: begin
        if (owner == OWN_I) begin
          i_ack = 1'b1;
          i_err = (state == S_FAULT);
          if (state == S_RESP) i_data = m_out;
        end else begin
          d_ack = 1'b1;
          d_err = (state == S_FAULT);
          if ((state == S_RESP) && !lat_ctl[3]) d_rdata = m_out;
        end
        // The requester being acked still holds its stale request this cycle,
        // so it may not be re-granted; if it would win, fall back to IDLE.
        grant_d = pick_d && (owner == OWN_I);
        grant_i = pick_i && (owner == OWN_D);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (grant_d)      state_n = mis_d ? S_FAULT : S_CMD;
    else if (grant_i) state_n = mis_i ? S_FAULT : S_CMD;
  end

  // Request latch, command registers, read-data capture and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      owner     <= OWN_I;
      lat_ctl   <= CTL_NONE;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      if (!i_req || grant_i)              cnt <= '0;
      else if (grant_d && cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (grant_d) begin
        owner   <= OWN_D;
        lat_ctl <= d_control;
        if (!mis_d) begin
          m_addr_q <= d_addr;
          m_data_q <= d_wdata;
        end
      end else if (grant_i) begin
        owner   <= OWN_I;
        lat_ctl <= CTL_FETCH;
        if (!mis_i) begin
          m_addr_q <= i_addr;
          m_data_q <= 32'd0;
        end
      end

      if (state == S_RESP) begin
        if (owner == OWN_I)     i_data_q  <= m_out;
        else if (!lat_ctl[3])   d_rdata_q <= m_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_memory_arbiter
// Purpose  : Directed self-checking bench for mips_memory_arbiter, with a
//            small memory datapath model behind the command port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ack, i_err;
  logic [31:0] i_data;
  logic        d_req;
  logic [3:0]  d_control;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [3:0]  m_control;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  mips_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_data(i_data),
    .d_req(d_req), .d_control(d_control), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_control(m_control), .m_addr(m_addr), .m_data(m_data), .m_out(m_out)
  );

  always #5 clk = ~clk;

  // Memory datapath model: executes a command seen at the clock edge,
  // read result (with extension) valid the following cycle.
  always @(posedge clk) begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[m_addr[7:2]];
    b = w[8*m_addr[1:0] +: 8];
    h = w[16*m_addr[1] +: 16];
    if (m_control[1:0] != 2'd0) begin
      if (m_control[3]) begin
        case (m_control[1:0])
          2'd1:    mem[m_addr[7:2]][8*m_addr[1:0] +: 8] <= m_data[7:0];
          2'd2:    mem[m_addr[7:2]][16*m_addr[1] +: 16] <= m_data[15:0];
          default: mem[m_addr[7:2]] <= m_data;
        endcase
      end else begin
        case (m_control[1:0])
          2'd1:    m_out <= m_control[2] ? {{24{b[7]}}, b} : {24'd0, b};
          2'd2:    m_out <= m_control[2] ? {{16{h[15]}}, h} : {16'd0, h};
          default: m_out <= w;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ack;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11111111;
    m_out  = 32'h0;
    rst_n = 1'b0; i_req = 1'b0; i_addr = 8'h0;
    d_req = 1'b0; d_control = 4'h0; d_addr = 8'h0; d_wdata = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_acks", {28'd0, i_ack, i_err, d_ack, d_err}, 32'h0);
    chk("rst_mctl", {28'd0, m_control}, 32'h0);
    chk("rst_maddr", {24'd0, m_addr}, 32'h0);
    chk("rst_mdata", m_data, 32'h0);
    chk("rst_idata", i_data, 32'h0);
    chk("rst_drdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_quiet", {27'd0, i_ack, i_err, d_ack, d_err, |m_control}, 32'h0);

    // Fetch at 0x10
    i_req = 1'b1; i_addr = 8'h10;
    tick();
    chk("fetch_c1_mctl", {28'd0, m_control}, 32'h3);
    chk("fetch_c1_maddr", {24'd0, m_addr}, 32'h10);
    chk("fetch_c1_ack", {31'd0, i_ack}, 32'h0);
    tick();
    chk("fetch_c2_ack", {30'd0, i_ack, i_err}, 32'h2);
    chk("fetch_c2_data", i_data, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();
    chk("fetch_c3_ack", {31'd0, i_ack}, 32'h0);
    chk("fetch_hold", i_data, 32'hDEADBEEF);

    // Byte store 0xA5 at 0x05
    d_req = 1'b1; d_control = 4'b1001; d_addr = 8'h05; d_wdata = 32'h000000A5;
    tick();
    chk("st_c1_mctl", {28'd0, m_control}, 32'h9);
    chk("st_c1_maddr", {24'd0, m_addr}, 32'h05);
    chk("st_c1_mdata", m_data, 32'hA5);
    tick();
    chk("st_c2_ack", {30'd0, d_ack, d_err}, 32'h2);
    chk("st_c2_mctl", {28'd0, m_control}, 32'h0);
    chk("st_c2_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    chk("st_mem", mem[1], 32'h0000A500);

    // Signed byte load at 0x05
    d_req = 1'b1; d_control = 4'b0101; d_addr = 8'h05;
    tick(); tick();
    chk("ld_ack", {30'd0, d_ack, d_err}, 32'h2);
    chk("ld_rdata", d_rdata, 32'hFFFFFFA5);
    d_req = 1'b0;
    tick();
    chk("ld_hold", d_rdata, 32'hFFFFFFA5);
    chk("ld_idata_hold", i_data, 32'hDEADBEEF);

    // Misaligned word at 0x06
    d_req = 1'b1; d_control = 4'b0011; d_addr = 8'h06;
    #1 chk("mis_c0_mctl", {28'd0, m_control}, 32'h0);
    tick();
    chk("mis_c1_ack", {30'd0, d_ack, d_err}, 32'h3);
    chk("mis_c1_mctl", {28'd0, m_control}, 32'h0);
    d_req = 1'b0;
    tick();
    chk("mis_c2_ack", {30'd0, d_ack, d_err}, 32'h0);
    chk("mis_rdata", d_rdata, 32'hFFFFFFA5);

    // Misaligned half at 0x05, then misaligned fetch at 0x12
    d_req = 1'b1; d_control = 4'b0010; d_addr = 8'h05;
    tick();
    chk("mish_ack", {30'd0, d_ack, d_err}, 32'h3);
    d_req = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 8'h12;
    tick();
    chk("misi_ack", {28'd0, i_ack, i_err, d_ack, d_err}, 32'hC);
    chk("misi_data", i_data, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();

    // Contention: both held, STARVE_MAX = 4
    i_req = 1'b1; i_addr = 8'h10;
    d_req = 1'b1; d_control = 4'b0011; d_addr = 8'h10;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 13 || k == 26) exp_ack = 2'b10;
      else if (k == 2 || k == 5 || k == 8 || k == 11 || k == 15 ||
               k == 18 || k == 21 || k == 24 || k == 28) exp_ack = 2'b01;
      else exp_ack = 2'b00;
      chk($sformatf("cont_ack_c%0d", k), {30'd0, i_ack, d_ack}, {30'd0, exp_ack});
      if (exp_ack == 2'b01) chk($sformatf("cont_drd_c%0d", k), d_rdata, 32'hDEADBEEF);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    chk("cont_end", {30'd0, i_ack, d_ack}, 32'h0);

    // Reset during CMD of a word store to 0x20
    d_req = 1'b1; d_control = 4'b1011; d_addr = 8'h20; d_wdata = 32'hCAFEF00D;
    tick();
    chk("rw_c1_mctl", {28'd0, m_control}, 32'hB);
    #2 rst_n = 1'b0;
    #1 chk("rw_async_mctl", {28'd0, m_control}, 32'h0);
    tick();
    chk("rw_noack", {30'd0, d_ack, d_err}, 32'h0);
    d_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rw_mem", mem[8], 32'h11111111);
    chk("rw_rdata_clr", d_rdata, 32'h0);
    chk("rw_idle", {29'd0, d_ack, |m_control, i_ack}, 32'h0);

    // FSM is idle after release: a fetch sees normal latency
    i_req = 1'b1; i_addr = 8'h10;
    tick();
    chk("post_c1_mctl", {28'd0, m_control}, 32'h3);
    tick();
    chk("post_c2_ack", {31'd0, i_ack}, 32'h1);
    chk("post_c2_data", i_data, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/mips_memory_arbiter.md
# mips_memory_arbiter

Sequencer and arbiter sharing the single Mips memory datapath port between the instruction-fetch requester and the data (load/store) requester. Requests are latched at grant and issued to the memory datapath as a registered command. Each requester gets a one-cycle acknowledge carrying read data or a misalignment fault. Data accesses have priority, with a starvation counter that guarantees fetch progress. Sits between pipeline fetch/memory stages and Mips_Datapath_Memory_datapath.

## Interface
- ADDR_L, 64, memory depth in words
- ADDR_W, Util_Math_log2(ADDR_L), word-address width; byte addresses are ADDR_W+2 bits
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits
- ctrl  input  Data_Control_Control_T  one clock, rising edge; reset is asynchronous and active-low
- i_req  input  1  fetch request, held with i_addr until i_ack
- i_addr  input  ADDR_W+2  fetch byte address, always a word access
- i_ack  output  1  one-cycle fetch acknowledge
- i_err  output  1  valid with i_ack: address misaligned
- i_data  output  32  fetched word
- d_req  input  1  data request, held with payload until d_ack
- d_control  input  Mips_Control_Type_Signal_Memory_Control_T  ByteEnable / ByteExtend / WriteEnable
- d_addr  input  ADDR_W+2  data byte address
- d_wdata  input  32  store data
- d_ack  output  1  one-cycle data acknowledge
- d_err  output  1  valid with d_ack: address misaligned
- d_rdata  output  32  load result
- m_control  output  Mips_Control_Type_Signal_Memory_Control_T  command to memory datapath
- m_addr  output  ADDR_W+2  command address
- m_data  output  32  command store data
- m_out  input  32  memory datapath read result, valid the cycle after the command

## Operation
- The FSM has four states: IDLE, CMD, RESP and FAULT.
- **Arbitration** happens in IDLE, and at the end of RESP/FAULT.
  - Winner: data if d_req is set, unless the starvation counter equals STARVE_MAX and i_req is set; then fetch wins.
  - At the end of RESP/FAULT, the requester currently being acknowledged is excluded.
- **Grant**: latch the winner's address, control and data.
  - A fetch is latched as ByteEnable Word, Unsigned, write disabled.
  - Next state is CMD if the request is aligned, FAULT if not.
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Byte and None accesses are never misaligned.
- **CMD**: m_control, m_addr and m_data drive the latched request, including WriteEnable. Next state is RESP.
- **RESP**: the winner's ack=1 and err=0.
  - On a read, the winner's rdata passes m_out combinationally and the rdata register captures it at the end of the cycle.
  - On a write, rdata holds its previous value.
- **FAULT**: the winner's ack=1 and err=1.
  - No memory command is issued and rdata holds.
- **Memory command outside CMD**: m_control is ByteEnable None with write disabled. m_addr and m_data hold their last value.
- **Starvation counter**:
  - Increments on each data grant while i_req is set, saturating at STARVE_MAX.
  - Clears on a fetch grant, or whenever i_req=0.
- **Ack and err**: the non-winner's ack and err are 0. err is 0 whenever ack is 0.

## Timing
- **Reset** (async, active-low) forces these values:
  - State IDLE, counter 0.
  - i_ack, d_ack, i_err, d_err all 0.
  - i_data, d_rdata registers 0.
  - m_control None with write disabled; m_addr 0, m_data 0.
- **Reset mid-operation** abandons the access. No ack is given, and a write in CMD is suppressed immediately because m_control goes None asynchronously.
- **Latency**:
  - Request sampled in IDLE at cycle 0 → CMD in cycle 1 → ack in cycle 2.
  - Misaligned: ack with err in cycle 1.
- **Back-to-back**:
  - If the other requester is pending at the end of RESP/FAULT, the FSM goes straight to CMD/FAULT (one access per 2 cycles).
  - The same requester re-requesting needs one IDLE cycle.
- **Handshake**:
  - The requester drops, or changes, req and payload in the cycle after ack.
  - Changing the payload before ack is illegal; the arbiter uses the latched copy.
- **Simultaneous i_req and d_req in IDLE**: data is granted unless the counter is saturated.
- Outputs i_data and d_rdata are stable except during own-read RESP and reset.

## Test plan
- **Reset**: deassert with i_req=d_req=0 → all acks/errs 0, m_control None, rdata 0; stays IDLE indefinitely.
- **Fetch**:
  - Stimulus: i_req, i_addr=0x10, mem word 0xDEADBEEF.
  - Required: m_control Word/read in cycle 1, m_addr=0x10; i_ack=1 and i_data=0xDEADBEEF in cycle 2; i_data holds afterwards.
- **Store then load**:
  - Store: d_req byte store d_addr=0x5, d_wdata=0x000000A5 → write-enabled Byte command in CMD only, d_ack in cycle 2, d_rdata unchanged.
  - Load: subsequent signed byte load at 0x5 → d_rdata=0xFFFFFFA5.
- **Misaligned**: d_req Word at 0x6 → d_ack=1 and d_err=1 in cycle 1; m_control stays None throughout.
- **Contention**: i_req and d_req held continuously with STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…; acks alternate with no IDLE gap between D→I and I→D transitions.
- **Reset mid-write**: assert reset during CMD of a store → write-enable drops same cycle, memory unchanged, no d_ack, FSM IDLE after release.
